// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// snake_pkg
// Shared constants and encodings for the snake controller and renderer.
// Revision: 1.0
// ============================================================================
package snake_pkg;

    localparam int c_GRID_SIZE = 15;
    localparam int c_MAX_LEN   = 8;

    typedef logic [3:0] coord_t;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_MOVE    = 3'd2,
        ST_RESPAWN = 3'd3,
        ST_OVER    = 3'd4
    } state_t;

    localparam coord_t     c_HEAD_X    = 4'd7;
    localparam coord_t     c_HEAD_Y    = 4'd7;
    localparam coord_t     c_SEG1_X    = 4'd6;
    localparam coord_t     c_SEG1_Y    = 4'd7;
    localparam coord_t     c_APPLE_X   = 4'd10;
    localparam coord_t     c_APPLE_Y   = 4'd4;
    localparam logic [3:0] c_RESET_LEN = 4'd2;

    // Opposite pairs differ only in bit 0 of the encoding.
    function automatic dir_t opposite_dir(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_timer.sv
`default_nettype none
// ============================================================================
// step_timer
// Counts enabled cycles; pulses done on the last one and wraps to zero.
// Revision: 1.0
// ============================================================================
module step_timer #(
    parameter int STEP_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic done
);

    localparam int              c_CW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(STEP_DIV - 1);

    logic [c_CW-1:0] r_cnt;

    assign done = en && (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr || done) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/snake_game_ctrl.sv
`default_nettype none
// ============================================================================
// snake_game_ctrl
// Snake game state machine: direction latch, movement, growth, apple respawn.
// Revision: 1.0
// ============================================================================
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int GRID_SIZE = c_GRID_SIZE,
    parameter int MAX_LEN   = c_MAX_LEN,
    parameter int STEP_DIV  = 25_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 up,
    input  logic                 down,
    input  logic                 left,
    input  logic                 right,
    input  logic [3:0]           apple_x_in,
    input  logic [3:0]           apple_y_in,
    input  logic                 apple_ack,
    output logic                 apple_req,
    output logic [3:0]           head_x,
    output logic [3:0]           head_y,
    output logic [4*MAX_LEN-1:0] seg_x,
    output logic [4*MAX_LEN-1:0] seg_y,
    output logic [MAX_LEN-1:0]   seg_valid,
    output logic [3:0]           apple_x,
    output logic [3:0]           apple_y,
    output logic [3:0]           length,
    output logic [7:0]           score,
    output logic                 game_over,
    output logic [2:0]           state
);

    localparam coord_t     c_LAST_CELL = 4'(GRID_SIZE - 1);
    localparam logic [3:0] c_MAX_LEN4  = 4'(MAX_LEN);

    state_t     r_state;
    dir_t       r_dir;
    dir_t       r_dir_pend;
    coord_t     r_seg_x [MAX_LEN];
    coord_t     r_seg_y [MAX_LEN];
    logic [3:0] r_len;
    logic [7:0] r_score;
    coord_t     r_apple_x;
    coord_t     r_apple_y;
    logic       r_apple_req;

    logic   w_done;
    logic   w_tmr_en;
    logic   w_tmr_clr;
    logic   w_btn_valid;
    dir_t   w_btn_dir;
    logic   w_dir_accept;
    coord_t w_next_x;
    coord_t w_next_y;
    logic   w_eat;
    logic   w_hit;
    logic   w_offer_ok;

    assign w_tmr_en  = (r_state == ST_RUN);
    assign w_tmr_clr = (r_state != ST_RUN);

    step_timer #(
        .STEP_DIV (STEP_DIV)
    ) u_step_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (w_tmr_en),
        .clr  (w_tmr_clr),
        .done (w_done)
    );

    // Only the highest-priority button counts; a reversal is dropped outright.
    always_comb begin
        w_btn_valid = right | left | up | down;
        w_btn_dir   = DIR_DOWN;
        if (right) begin
            w_btn_dir = DIR_RIGHT;
        end else if (left) begin
            w_btn_dir = DIR_LEFT;
        end else if (up) begin
            w_btn_dir = DIR_UP;
        end
        w_dir_accept = w_btn_valid && (w_btn_dir != opposite_dir(r_dir));
    end

    always_comb begin
        w_next_x = r_seg_x[0];
        w_next_y = r_seg_y[0];
        case (r_dir_pend)
            DIR_RIGHT: w_next_x = (r_seg_x[0] == c_LAST_CELL) ? 4'd0 : r_seg_x[0] + 4'd1;
            DIR_LEFT:  w_next_x = (r_seg_x[0] == 4'd0) ? c_LAST_CELL : r_seg_x[0] - 4'd1;
            DIR_UP:    w_next_y = (r_seg_y[0] == 4'd0) ? c_LAST_CELL : r_seg_y[0] - 4'd1;
            default:   w_next_y = (r_seg_y[0] == c_LAST_CELL) ? 4'd0 : r_seg_y[0] + 4'd1;
        endcase
    end

    // The tail normally vacates on a move, but not when the snake grows.
    always_comb begin
        w_eat = (w_next_x == r_apple_x) && (w_next_y == r_apple_y);
        w_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((r_seg_x[i] == w_next_x) && (r_seg_y[i] == w_next_y) &&
                (((i + 1) < int'(r_len)) || (w_eat && (i < int'(r_len))))) begin
                w_hit = 1'b1;
            end
        end
    end

    always_comb begin
        w_offer_ok = (apple_x_in <= c_LAST_CELL) && (apple_y_in <= c_LAST_CELL);
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((i < int'(r_len)) && (r_seg_x[i] == apple_x_in) && (r_seg_y[i] == apple_y_in)) begin
                w_offer_ok = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_dir      <= DIR_RIGHT;
            r_dir_pend <= DIR_RIGHT;
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= '0;
                r_seg_y[i] <= '0;
            end
            r_seg_x[0]  <= c_HEAD_X;
            r_seg_y[0]  <= c_HEAD_Y;
            r_seg_x[1]  <= c_SEG1_X;
            r_seg_y[1]  <= c_SEG1_Y;
            r_len       <= c_RESET_LEN;
            r_score     <= 8'd0;
            r_apple_x   <= c_APPLE_X;
            r_apple_y   <= c_APPLE_Y;
            r_apple_req <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_dir_accept) r_dir_pend <= w_btn_dir;
                    if (w_btn_valid)  r_state    <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_dir_accept) r_dir_pend <= w_btn_dir;
                    if (w_done)       r_state    <= ST_MOVE;
                end
                ST_MOVE: begin
                    if (w_hit) begin
                        r_state <= ST_OVER;
                    end else begin
                        for (int i = 1; i < MAX_LEN; i++) begin
                            r_seg_x[i] <= r_seg_x[i-1];
                            r_seg_y[i] <= r_seg_y[i-1];
                        end
                        r_seg_x[0] <= w_next_x;
                        r_seg_y[0] <= w_next_y;
                        r_dir      <= r_dir_pend;
                        if (w_eat) begin
                            if (r_len != c_MAX_LEN4) r_len   <= r_len + 4'd1;
                            if (r_score != 8'hFF)    r_score <= r_score + 8'd1;
                            r_apple_req <= 1'b1;
                            r_state     <= ST_RESPAWN;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RESPAWN: begin
                    if (w_dir_accept) r_dir_pend <= w_btn_dir;
                    if (apple_ack && w_offer_ok) begin
                        r_apple_x   <= apple_x_in;
                        r_apple_y   <= apple_y_in;
                        r_apple_req <= 1'b0;
                        r_state     <= ST_RUN;
                    end
                end
                ST_OVER: begin
                    r_state <= ST_OVER;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_seg_out
        assign seg_x[4*g +: 4] = r_seg_x[g];
        assign seg_y[4*g +: 4] = r_seg_y[g];
        assign seg_valid[g]    = (4'(g) < r_len);
    end

    assign head_x    = r_seg_x[0];
    assign head_y    = r_seg_y[0];
    assign apple_x   = r_apple_x;
    assign apple_y   = r_apple_y;
    assign apple_req = r_apple_req;
    assign length    = r_len;
    assign score     = r_score;
    assign game_over = (r_state == ST_OVER);
    assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_snake_game_ctrl.sv
`default_nettype none
// ============================================================================
// tb_snake_game_ctrl
// Directed self-checking bench for snake_game_ctrl with STEP_DIV = 4.
// Revision: 1.0
// ============================================================================
module tb_snake_game_ctrl;

    localparam int MAX_LEN = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 up = 1'b0;
    logic                 down = 1'b0;
    logic                 left = 1'b0;
    logic                 right = 1'b0;
    logic [3:0]           apple_x_in = 4'd0;
    logic [3:0]           apple_y_in = 4'd0;
    logic                 apple_ack = 1'b0;
    logic                 apple_req;
    logic [3:0]           head_x;
    logic [3:0]           head_y;
    logic [4*MAX_LEN-1:0] seg_x;
    logic [4*MAX_LEN-1:0] seg_y;
    logic [MAX_LEN-1:0]   seg_valid;
    logic [3:0]           apple_x;
    logic [3:0]           apple_y;
    logic [3:0]           length;
    logic [7:0]           score;
    logic                 game_over;
    logic [2:0]           state;

    int n_vec  = 0;
    int n_miss = 0;

    snake_game_ctrl #(
        .GRID_SIZE (15),
        .MAX_LEN   (MAX_LEN),
        .STEP_DIV  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .up         (up),
        .down       (down),
        .left       (left),
        .right      (right),
        .apple_x_in (apple_x_in),
        .apple_y_in (apple_y_in),
        .apple_ack  (apple_ack),
        .apple_req  (apple_req),
        .head_x     (head_x),
        .head_y     (head_y),
        .seg_x      (seg_x),
        .seg_y      (seg_y),
        .seg_valid  (seg_valid),
        .apple_x    (apple_x),
        .apple_y    (apple_y),
        .length     (length),
        .score      (score),
        .game_over  (game_over),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // b: 0 right, 1 left, 2 up, 3 down
    task automatic pulse(input int b);
        right = (b == 0);
        left  = (b == 1);
        up    = (b == 2);
        down  = (b == 3);
        tick;
        right = 1'b0;
        left  = 1'b0;
        up    = 1'b0;
        down  = 1'b0;
    endtask

    task automatic wait_step(input string tag, input int exp_cyc, input int ex, input int ey);
        logic [3:0] hx0;
        logic [3:0] hy0;
        int         n;
        hx0 = head_x;
        hy0 = head_y;
        n   = 0;
        while ((head_x == hx0) && (head_y == hy0) && (n < 12)) begin
            tick;
            n++;
        end
        check_val({tag, "_cyc"}, n, exp_cyc);
        check_val({tag, "_x"}, head_x, ex);
        check_val({tag, "_y"}, head_y, ey);
    endtask

    task automatic offer(input int ax, input int ay);
        apple_x_in = 4'(ax);
        apple_y_in = 4'(ay);
        apple_ack  = 1'b1;
        tick;
        apple_ack  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int moved;
        int n;

        // Reset and idle
        repeat (3) tick;
        rst = 1'b0;
        check_val("rst_head_x", head_x, 7);
        check_val("rst_head_y", head_y, 7);
        check_val("rst_seg1_x", seg_x[7:4], 6);
        check_val("rst_seg1_y", seg_y[7:4], 7);
        check_val("rst_len", length, 2);
        check_val("rst_state", state, 0);
        check_val("rst_score", score, 0);
        check_val("rst_apple_x", apple_x, 10);
        check_val("rst_apple_y", apple_y, 4);
        check_val("rst_req", apple_req, 0);
        check_val("rst_over", game_over, 0);
        check_val("rst_valid", seg_valid, 8'h03);
        moved = 0;
        repeat (100) begin
            tick;
            if (head_x != 4'd7 || head_y != 4'd7 || state != 3'd0) moved = 1;
        end
        check_val("idle_still", moved, 0);

        // Start right and wrap around the x edge
        pulse(0);
        wait_step("step1", 5, 8, 7);
        check_val("step1_seg1_x", seg_x[7:4], 7);
        check_val("step1_seg1_y", seg_y[7:4], 7);
        for (int k = 9; k <= 15; k++) wait_step("wrap", 5, k % 15, 7);

        // Reversal ignored, perpendicular turn honoured
        pulse(1);
        wait_step("rev_left", 4, 1, 7);
        pulse(2);
        wait_step("turn_up", 4, 1, 6);
        wait_step("up_a", 5, 1, 5);
        wait_step("up_b", 5, 1, 4);
        pulse(0);
        wait_step("go_right", 4, 2, 4);
        for (int k = 3; k <= 10; k++) wait_step("to_apple", 5, k, 4);

        // Eat at (10,4) and respawn handshake
        check_val("eat1_len", length, 3);
        check_val("eat1_score", score, 1);
        check_val("eat1_req", apple_req, 1);
        check_val("eat1_state", state, 3);
        check_val("eat1_valid", seg_valid, 8'h07);
        check_val("eat1_seg2_x", seg_x[11:8], 8);
        offer(15, 3);
        check_val("rej_range_req", apple_req, 1);
        check_val("rej_range_state", state, 3);
        offer(10, 4);
        check_val("rej_body_req", apple_req, 1);
        check_val("rej_body_ax", apple_x, 10);
        repeat (6) tick;
        check_val("respawn_hold_x", head_x, 10);
        check_val("respawn_state", state, 3);
        offer(2, 2);
        check_val("acc_ax", apple_x, 2);
        check_val("acc_ay", apple_y, 2);
        check_val("acc_req", apple_req, 0);
        check_val("acc_state", state, 1);
        wait_step("resume", 5, 11, 4);

        // Grow to length 5 then curl back into the body
        for (int k = 12; k <= 17; k++) wait_step("to_col2", 5, k % 15, 4);
        pulse(2);
        wait_step("up2_a", 4, 2, 3);
        wait_step("up2_b", 5, 2, 2);
        check_val("eat2_len", length, 4);
        check_val("eat2_score", score, 2);
        check_val("eat2_req", apple_req, 1);
        offer(3, 2);
        check_val("acc2_state", state, 1);
        pulse(0);
        wait_step("eat3", 4, 3, 2);
        check_val("eat3_len", length, 5);
        check_val("eat3_score", score, 3);
        offer(12, 12);
        check_val("acc3_state", state, 1);
        pulse(2);
        wait_step("curl_up", 4, 3, 1);
        pulse(1);
        wait_step("curl_left", 4, 2, 1);
        pulse(3);
        n = 0;
        while (!game_over && n < 12) begin
            tick;
            n++;
        end
        check_val("over_cyc", n, 4);
        check_val("over_state", state, 4);
        check_val("over_head_x", head_x, 2);
        check_val("over_head_y", head_y, 1);
        check_val("over_seg1_x", seg_x[7:4], 3);
        check_val("over_len", length, 5);
        check_val("over_score", score, 3);

        // OVER is terminal
        up = 1'b1;
        left = 1'b1;
        apple_x_in = 4'd5;
        apple_y_in = 4'd5;
        apple_ack = 1'b1;
        moved = 0;
        repeat (20) begin
            tick;
            if (head_x != 4'd2 || head_y != 4'd1 || state != 3'd4) moved = 1;
        end
        up = 1'b0;
        left = 1'b0;
        apple_ack = 1'b0;
        check_val("frozen", moved, 0);
        check_val("frozen_ax", apple_x, 12);
        check_val("frozen_ay", apple_y, 12);
        check_val("frozen_req", apple_req, 0);
        check_val("frozen_len", length, 5);

        // Reset out of OVER; left in IDLE starts but keeps direction right
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_val("rst2_state", state, 0);
        check_val("rst2_head_x", head_x, 7);
        check_val("rst2_len", length, 2);
        check_val("rst2_over", game_over, 0);
        pulse(1);
        wait_step("idle_left", 5, 8, 7);
        pulse(2);
        wait_step("d_up_a", 4, 8, 6);
        wait_step("d_up_b", 5, 8, 5);
        wait_step("d_up_c", 5, 8, 4);
        pulse(0);
        wait_step("d_r_a", 4, 9, 4);
        wait_step("d_r_b", 5, 10, 4);
        check_val("d_req", apple_req, 1);
        check_val("d_state", state, 3);

        // Reset in the middle of RESPAWN
        rst = 1'b1;
        tick;
        check_val("rst3_req", apple_req, 0);
        check_val("rst3_state", state, 0);
        check_val("rst3_len", length, 2);
        check_val("rst3_score", score, 0);
        check_val("rst3_head_x", head_x, 7);
        rst = 1'b0;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
